aes128_encrypt_core: RTL and testbench
======================================

Name: aes128_encrypt_core

Overview:
- Iterative AES-128 encryption core with on-the-fly key expansion and valid/ready handshakes on both input and output.
- UNROLL rounds execute per clock, so one build can trade area against latency.
- Built from the team's existing subBytes / shiftRows / mixColumns / addRoundKey cells, plus a local 4-byte SubWord for key expansion.
- Sits between the block-mode controller (upstream) and the ciphertext buffer (downstream).

Parameters:
- UNROLL, 1, rounds computed per clock. Legal values: 1, 2, 5, 10. Any other value is a fatal elaboration error.
- DATA_W, 128, block/key width. Fixed at 128; any other value is an elaboration error. Exists for port-width symmetry only.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  plaintext and key presented
- in_ready  output  1  core can accept a block this cycle
- plaintext  input  128  byte 0 = bits [127:120]
- key  input  128  cipher key, same byte order as plaintext
- out_valid  output  1  ciphertext available
- out_ready  input  1  downstream accepts ciphertext
- ciphertext  output  128  result, same byte order as plaintext
- busy  output  1  high in RUN state

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, round_ctr=0, state_reg=0, rkey_reg=0.
  - Outputs: in_ready=0 while rst_n=0; out_valid=0; busy=0; ciphertext=0.
  - Assertion mid-operation discards the block in flight; no partial output is ever emitted.
- States: IDLE, RUN, DONE.
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
  - out_valid = (state==DONE).
  - busy = (state==RUN).
- Accept (in_valid && in_ready at edge E):
  - state_reg <= plaintext XOR key (round 0 AddRoundKey).
  - rkey_reg <= key; round_ctr <= 1; state <= RUN.
- RUN, each cycle: apply UNROLL consecutive rounds r = round_ctr .. round_ctr+UNROLL-1.
  - Round key for round r is derived from the previous round key: w0' = w0 XOR SubWord(RotWord(w3)) XOR Rcon[r]; subsequent words chain.
  - Rcon sequence: 01,02,04,08,10,20,40,80,1B,36.
  - Rounds 1..9: SubBytes -> ShiftRows -> MixColumns -> AddRoundKey.
  - Round 10: MixColumns bypassed.
  - Registers: round_ctr += UNROLL; state_reg and rkey_reg updated.
  - When round_ctr+UNROLL-1 == 10, state <= DONE.
- Latency: out_valid rises 10/UNROLL edges after the accept edge (10, 5, 2, 1 for UNROLL = 1, 2, 5, 10).
- DONE:
  - ciphertext is held stable while out_valid=1 && out_ready=0. No timeout.
  - out_ready=1 with in_valid=0: state <= IDLE.
  - out_ready=1 with in_valid=1: the new block is accepted on the same edge, state <= RUN. Back-to-back throughput is one block per 10/UNROLL+1 cycles.
- in_valid in RUN is ignored: in_ready=0, and inputs are not sampled.
- plaintext and key are sampled only on the accept edge; they may change afterwards.
- round_ctr never exceeds 10; it returns to 1 only on a new accept.

Optional Feature:
- Macro: AES_OUT_ZEROIZE_EN.
- Defined:
  - ciphertext is forced to 0 whenever out_valid=0, so intermediate round state never appears on the port.
  - state_reg and rkey_reg are cleared to 0 on the edge the output is consumed, when no new block is accepted on that edge.
- Undefined:
  - ciphertext = state_reg at all times, so intermediate states are visible during RUN.
  - Registers retain their last values in IDLE.
  - Cycle timing is identical in both builds.

Test Plan:
- FIPS-197 App. B, UNROLL=1: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> out_valid exactly 10 cycles after accept, ciphertext 3925841d02dc09fbdc118597196a0b32.
- FIPS-197 App. C.1, UNROLL ∈ {2, 5, 10}: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a at latency 5 / 2 / 1.
- Backpressure: hold out_ready=0 for 7 cycles after out_valid -> ciphertext stable, in_ready=0 and a toggling in_valid is ignored; then out_ready=1 together with in_valid=1 and the App. C.1 vector -> same-edge accept, second result correct.
- Reset mid-RUN: assert rst_n=0 at round 4 -> out_valid=0 and busy=0 immediately; after release, the App. B vector completes correctly with no stale output.
- AES_OUT_ZEROIZE_EN defined: ciphertext reads 0 in every RUN cycle and after consumption; undefined: ciphertext equals the round-1 state (App. B: a49c7ff2689f352b6b5bea43026a5049) one cycle after accept.
- Stream of 20 random blocks with random in_valid/out_ready stalls, compared against a reference model -> zero mismatches, no dropped or duplicated blocks.

Source files
------------

// File: rtl/aes128_encrypt_core.sv
// Iterative AES-128 encryptor: UNROLL rounds per clock with on-the-fly key expansion.
// Build macro AES_OUT_ZEROIZE_EN blanks ciphertext unless valid and clears state/key after consumption.
module aes128_encrypt_core #(
  parameter int unsigned UNROLL = 1,
  parameter int unsigned DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] plaintext,
  input  logic [DATA_W-1:0] key,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ciphertext,
  output logic              busy
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
    $fatal(1, "aes128_encrypt_core: UNROLL must be 1, 2, 5 or 10");
  end
  if (DATA_W != 128) begin : g_bad_width
    $fatal(1, "aes128_encrypt_core: DATA_W must be 128");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [3:0] STEP = 4'(UNROLL);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX[(255 - int'(b)) * 8 +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] next_rkey(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned i = 0; i < 16; i++) o[i*8 +: 8] = sub_byte(s[i*8 +: 8]);
    return o;
  endfunction

  // byte index 4*c + r lives at bits [127-8*(4*c+r) -: 8] (column-major)
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
    return o;
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [127:0] t;
    t = shift_rows(sub_bytes(s));
    if (!last) t = {mix_column(t[127:96]), mix_column(t[95:64]),
                    mix_column(t[63:32]), mix_column(t[31:0])};
    return t ^ rk;
  endfunction

  state_e       fsm_q, fsm_d;
  logic [3:0]   ctr_q, ctr_d;
  logic [127:0] state_q, state_d;
  logic [127:0] rkey_q, rkey_d;
  logic [127:0] run_state, run_key;
  logic         accept, last_step;

  always_comb begin
    logic [3:0] rnd;
    rnd       = ctr_q;
    run_state = state_q;
    run_key   = rkey_q;
    for (int unsigned i = 0; i < UNROLL; i++) begin
      rnd       = ctr_q + 4'(i);
      run_key   = next_rkey(run_key, rcon(rnd));
      run_state = enc_round(run_state, run_key, rnd == 4'd10);
    end
  end

  assign in_ready  = rst_n && ((fsm_q == IDLE) || (fsm_q == DONE && out_ready));
  assign out_valid = (fsm_q == DONE);
  assign busy      = (fsm_q == RUN);
  assign accept    = in_valid && in_ready;
  assign last_step = (ctr_q + STEP) == 4'd11;

`ifdef AES_OUT_ZEROIZE_EN
  assign ciphertext = out_valid ? state_q : '0;
`else
  assign ciphertext = state_q;
`endif

  always_comb begin
    fsm_d   = fsm_q;
    ctr_d   = ctr_q;
    state_d = state_q;
    rkey_d  = rkey_q;
    case (fsm_q)
      RUN: begin
        state_d = run_state;
        rkey_d  = run_key;
        ctr_d   = last_step ? 4'd10 : ctr_q + STEP;
        if (last_step) fsm_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          fsm_d = IDLE;
`ifdef AES_OUT_ZEROIZE_EN
          state_d = '0;
          rkey_d  = '0;
`endif
        end
      end
      default: ;
    endcase
    // a same-edge accept in DONE overrides the consume path above
    if (accept) begin
      fsm_d   = RUN;
      ctr_d   = 4'd1;
      state_d = plaintext ^ key;
      rkey_d  = key;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      ctr_q   <= '0;
      state_q <= '0;
      rkey_q  <= '0;
    end else begin
      fsm_q   <= fsm_d;
      ctr_q   <= ctr_d;
      state_q <= state_d;
      rkey_q  <= rkey_d;
    end
  end

endmodule

// File: tb/tb_aes128_encrypt_core.sv
// Bench for aes128_encrypt_core: FIPS-197 vectors, backpressure, reset, random stream vs reference model.
module tb_aes128_encrypt_core;

  localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_R1  = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] plaintext, key, ciphertext;

  logic         kat_valid;
  logic [127:0] kat_pt, kat_key;
  logic         u2_ir, u2_ov, u2_busy, u5_ir, u5_ov, u5_busy, u10_ir, u10_ov, u10_busy;
  logic [127:0] u2_ct, u5_ct, u10_ct;

  int n_checks = 0;
  int n_errors = 0;
  int n_out = 0;
  logic [127:0] sb_q[$];
  logic [7:0]   ref_sbox[256];

  always #5 clk = ~clk;

  aes128_encrypt_core #(.UNROLL(1), .DATA_W(128)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .plaintext(plaintext), .key(key), .out_valid(out_valid), .out_ready(out_ready),
    .ciphertext(ciphertext), .busy(busy));

  aes128_encrypt_core #(.UNROLL(2), .DATA_W(128)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(kat_valid), .in_ready(u2_ir),
    .plaintext(kat_pt), .key(kat_key), .out_valid(u2_ov), .out_ready(1'b1),
    .ciphertext(u2_ct), .busy(u2_busy));

  aes128_encrypt_core #(.UNROLL(5), .DATA_W(128)) u5 (
    .clk(clk), .rst_n(rst_n), .in_valid(kat_valid), .in_ready(u5_ir),
    .plaintext(kat_pt), .key(kat_key), .out_valid(u5_ov), .out_ready(1'b1),
    .ciphertext(u5_ct), .busy(u5_busy));

  aes128_encrypt_core #(.UNROLL(10), .DATA_W(128)) u10 (
    .clk(clk), .rst_n(rst_n), .in_valid(kat_valid), .in_ready(u10_ir),
    .plaintext(kat_pt), .key(kat_key), .out_valid(u10_ov), .out_ready(1'b1),
    .ciphertext(u10_ct), .busy(u10_busy));

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: S-box from GF(2^8) inverse + affine map, full key schedule up front
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      ref_sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
    logic [7:0]  s[16], t[16], a[4];
    logic [31:0] w[44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    logic [127:0] o;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {ref_sbox[tmp[23:16]], ref_sbox[tmp[15:8]], ref_sbox[tmp[7:0]], ref_sbox[tmp[31:24]]}
              ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = ref_sbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
      if (rnd < 10)
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) a[r] = s[4*c+r];
          for (int r = 0; r < 4; r++)
            s[4*c+r] = gmul(8'h02, a[r]) ^ gmul(8'h03, a[(r+1)%4]) ^ a[(r+2)%4] ^ a[(r+3)%4];
        end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // Scoreboard: push on accept, pop on consume; flushed while reset is asserted
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        check_eq("sb_has_entry", 128'(sb_q.size() != 0), 128'd1);
        if (sb_q.size() != 0) check_eq("sb_ciphertext", ciphertext, sb_q.pop_front());
        n_out++;
      end
      if (in_valid && in_ready) sb_q.push_back(aes_ref(plaintext, key));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lat2, lat5, lat10, acc, cyc, start_out;
    logic hs;
    logic [127:0] ct2, ct5, ct10;
    build_sbox();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; plaintext = '0; key = '0;
    kat_valid = 1'b0; kat_pt = C_PT; kat_key = C_KEY;
    tick(); tick();
    check_eq("rst_in_ready", 128'(in_ready), 128'd0);
    check_eq("rst_out_valid", 128'(out_valid), 128'd0);
    check_eq("rst_busy", 128'(busy), 128'd0);
    check_eq("rst_ciphertext", ciphertext, '0);
    rst_n = 1'b1;
    #1;
    check_eq("idle_in_ready", 128'(in_ready), 128'd1);

    // UNROLL 2/5/10 latency and App C.1 result
    kat_valid = 1'b1;
    #1;
    check_eq("kat_in_ready", 128'({u2_ir, u5_ir, u10_ir}), 128'd7);
    tick();
    kat_valid = 1'b0;
    check_eq("kat_busy", 128'({u2_busy, u5_busy, u10_busy}), 128'd7);
    lat2 = 0; lat5 = 0; lat10 = 0; ct2 = '0; ct5 = '0; ct10 = '0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (u2_ov && lat2 == 0) begin lat2 = c; ct2 = u2_ct; end
      if (u5_ov && lat5 == 0) begin lat5 = c; ct5 = u5_ct; end
      if (u10_ov && lat10 == 0) begin lat10 = c; ct10 = u10_ct; end
    end
    check_eq("u2_latency", 128'(lat2), 128'd5);
    check_eq("u5_latency", 128'(lat5), 128'd2);
    check_eq("u10_latency", 128'(lat10), 128'd1);
    check_eq("u2_ct", ct2, C_CT);
    check_eq("u5_ct", ct5, C_CT);
    check_eq("u10_ct", ct10, C_CT);

    // App B on UNROLL=1 with latency, intermediate state visibility, then backpressure
    in_valid = 1'b1; plaintext = B_PT; key = B_KEY;
    tick();
    in_valid = 1'b0; plaintext = '0; key = '0;
    check_eq("b_busy", 128'(busy), 128'd1);
    check_eq("b_in_ready_run", 128'(in_ready), 128'd0);
`ifdef AES_OUT_ZEROIZE_EN
    check_eq("b_ct_round0", ciphertext, '0);
`else
    check_eq("b_ct_round0", ciphertext, B_PT ^ B_KEY);
`endif
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
`ifdef AES_OUT_ZEROIZE_EN
      if (!out_valid) check_eq("b_ct_zero_run", ciphertext, '0);
`else
      if (lat == 1) check_eq("b_ct_round1", ciphertext, B_R1);
`endif
    end
    check_eq("b_latency", 128'(lat), 128'd10);
    check_eq("b_ct", ciphertext, B_CT);
    for (int c = 0; c < 7; c++) begin
      tick();
      in_valid = c[0];
      plaintext = {$urandom(), $urandom(), $urandom(), $urandom()};
      #1;
      check_eq("bp_ct_stable", ciphertext, B_CT);
      check_eq("bp_in_ready", 128'(in_ready), 128'd0);
      check_eq("bp_out_valid", 128'(out_valid), 128'd1);
    end
    in_valid = 1'b1; out_ready = 1'b1; plaintext = C_PT; key = C_KEY;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check_eq("b2b_busy", 128'(busy), 128'd1);
    check_eq("b2b_out_valid", 128'(out_valid), 128'd0);
    lat = 0;
    while (!out_valid && lat < 50) begin tick(); lat++; end
    check_eq("b2b_latency", 128'(lat), 128'd10);
    check_eq("b2b_ct", ciphertext, C_CT);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("consumed_out_valid", 128'(out_valid), 128'd0);
`ifdef AES_OUT_ZEROIZE_EN
    check_eq("consumed_ct", ciphertext, '0);
`else
    check_eq("consumed_ct", ciphertext, C_CT);
`endif

    // Reset at round 4, then a clean App B run
    in_valid = 1'b1; out_ready = 1'b1; plaintext = B_PT; key = B_KEY;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", 128'(out_valid), 128'd0);
    check_eq("mid_rst_busy", 128'(busy), 128'd0);
    check_eq("mid_rst_in_ready", 128'(in_ready), 128'd0);
    check_eq("mid_rst_ct", ciphertext, '0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_out_valid", 128'(out_valid), 128'd0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin tick(); lat++; end
    check_eq("post_rst_latency", 128'(lat), 128'd10);
    check_eq("post_rst_ct", ciphertext, B_CT);
    tick();
    out_ready = 1'b0;
    check_eq("post_rst_sb_empty", 128'(sb_q.size()), 128'd0);

    // Random stream with input and output stalls
    acc = 0; cyc = 0; start_out = n_out;
    while ((acc < 20 || n_out - start_out < 20) && cyc < 4000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (acc < 20 && !in_valid && $urandom_range(0, 2) != 0) begin
        in_valid  = 1'b1;
        plaintext = {$urandom(), $urandom(), $urandom(), $urandom()};
        key       = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      #2;
      hs = in_valid && in_ready;
      tick();
      cyc++;
      if (hs) begin
        acc++;
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    check_eq("rand_accepted", 128'(acc), 128'd20);
    check_eq("rand_outputs", 128'(n_out - start_out), 128'd20);
    check_eq("rand_sb_empty", 128'(sb_q.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
